md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It is the successor to the fixed 32-bit MD unit.
- New relative to that unit:
  - configurable datapath width and per-class latency;
  - a flush input so interrupt/exception entry can cancel an issuing operation;
  - defined divide-by-zero and overflow results;
  - optional multiply-accumulate.
- The CU stalls D while (busy | start) and an MD-class instruction sits in D.

---
 rtl/md_pkg.sv | 51 +++++
 rtl/md_lat_cnt.sv | 30 +++
 rtl/md_unit.sv | 156 +++++++++++++++
 tb/tb_md_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the multiply/divide unit.
// MD_MADD_EN enables the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU).
`default_nettype none

package md_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd10;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd11;
  localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd12;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  function automatic logic is_mul_class(input logic [MD_OP_W-1:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic is_div_class(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mt(input logic [MD_OP_W-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic is_signed_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_lat_cnt.sv
// Loadable down-counter; o_done flags the final counted cycle (count == 1).
`default_nettype none

module md_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed-latency completion.
// MD_MADD_EN adds multiply-accumulate/subtract ops 9-12 on the multiply latency.
`default_nettype none

module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   md_out
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_t          r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_p_hi;
  logic [WIDTH-1:0]   r_p_lo;

  logic               w_sgn;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_issue;
  logic               w_mt_wr;
  logic               w_done;
  logic [CNT_W-1:0]   w_load_val;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_ovf;
  logic [2*WIDTH-1:0] w_pend;

  assign w_sgn    = is_signed_op(md_op);
  assign w_is_mul = is_mul_class(md_op);
  assign w_is_div = is_div_class(md_op);
  assign w_issue  = start & ~flush & (r_state == S_IDLE) & (w_is_mul | w_is_div);
  assign w_mt_wr  = start & ~flush & ~r_busy & is_mt(md_op);

  assign w_load_val = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // Sign-extended 2W x 2W product truncated to 2W is the exact signed/unsigned product.
  assign w_a_ext = {{WIDTH{w_sgn & rs[WIDTH-1]}}, rs};
  assign w_b_ext = {{WIDTH{w_sgn & rt[WIDTH-1]}}, rt};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes; divisor forced non-zero so the datapath never goes X.
  assign w_a_neg  = w_sgn & rs[WIDTH-1];
  assign w_b_neg  = w_sgn & rt[WIDTH-1];
  assign w_a_abs  = w_a_neg ? (~rs + WIDTH'(1)) : rs;
  assign w_b_abs  = w_b_neg ? (~rt + WIDTH'(1)) : rt;
  assign w_b_safe = (rt == '0) ? WIDTH'(1) : w_b_abs;
  assign w_q_u    = w_a_abs / w_b_safe;
  assign w_r_u    = w_a_abs % w_b_safe;
  assign w_quo    = (w_a_neg ^ w_b_neg) ? (~w_q_u + WIDTH'(1)) : w_q_u;
  assign w_rem    = w_a_neg ? (~w_r_u + WIDTH'(1)) : w_r_u;
  assign w_ovf    = (md_op == MD_DIV) && (rs == {1'b1, {(WIDTH-1){1'b0}}}) && (rt == '1);

  always_comb begin
    w_pend = w_prod;
    if (w_is_div) begin
      if (rt == '0) begin
        w_pend = {rs, {WIDTH{1'b1}}};
      end else if (w_ovf) begin
        w_pend = {{WIDTH{1'b0}}, rs};
      end else begin
        w_pend = {w_rem, w_quo};
      end
    end
`ifdef MD_MADD_EN
    else if ((md_op == MD_MADD) || (md_op == MD_MADDU)) begin
      w_pend = {r_hi, r_lo} + w_prod;
    end else if ((md_op == MD_MSUB) || (md_op == MD_MSUBU)) begin
      w_pend = {r_hi, r_lo} - w_prod;
    end
`endif
  end

  md_lat_cnt #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .i_load    (w_issue),
    .i_load_val(w_load_val),
    .o_done    (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            {r_p_hi, r_p_lo} <= w_pend;
            r_busy           <= 1'b1;
            r_state          <= S_RUN;
          end else if (w_mt_wr) begin
            if (md_op == MD_MTHI) r_hi <= rs;
            else                  r_lo <= rs;
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_hi    <= r_p_hi;
            r_lo    <= r_p_lo;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign md_out = (md_op == MD_MFHI) ? r_hi :
                  (md_op == MD_MFLO) ? r_lo : '0;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit at default parameters.
`default_nettype none

module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic        flush;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int checks;
  int failures;

  md_unit #(
    .WIDTH     (32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .start (start),
    .flush (flush),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .md_out(md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; drives one issue cycle and returns at the next posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    md_op = op; rs = a; rt = b; start = 1'b1; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; md_op = 4'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    md_op = 4'd6;
    #1;
    checks++;
    if (md_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mflo: md_out=%h required 0", md_out);
    end
    md_op = 4'd0;
  endtask

  task automatic test_mult;
    int n;
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL mult: cyc=%0d hi=%h lo=%h required cyc=5 hi=ffffffff lo=fffffffa", n, hi, lo);
    end
    issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL multu: cyc=%0d hi=%h lo=%h required cyc=5 hi=00000002 lo=fffffffa", n, hi, lo);
    end
  endtask

  task automatic test_div;
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failures++;
      $display("FAIL div_signed: cyc=%0d hi=%h lo=%h required cyc=10 hi=ffffffff lo=fffffffd", n, hi, lo);
    end
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'h00000007 || lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL divu_zero: cyc=%0d hi=%h lo=%h required cyc=10 hi=00000007 lo=ffffffff", n, hi, lo);
    end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    count_busy(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      failures++;
      $display("FAIL div_ovf: hi=%h lo=%h required hi=00000000 lo=80000000", hi, lo);
    end
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL divu_plain: hi=%h lo=%h required hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise: busy=%b required 1", busy);
    end
    issue(4'd7, 32'h1234, 32'd0, 1'b0);
    issue(4'd1, 32'd9, 32'd9, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 3 || hi !== 32'h0 || lo !== 32'd12) begin
      failures++;
      $display("FAIL busy_ignore: rem=%0d hi=%h lo=%h required rem=3 hi=00000000 lo=0000000c", n, hi, lo);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd12) begin
      failures++;
      $display("FAIL busy_ignore_late: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=c", busy, hi, lo);
    end
  endtask

  task automatic test_async_reset;
    issue(4'd7, 32'h77, 32'd0, 1'b0);
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: busy=%b required 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL areset: busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", busy, hi, lo);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    md_op = 4'd6;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (md_out !== 32'h0 || busy !== 1'b0 || hi !== 32'h0) begin
      failures++;
      $display("FAIL areset_after: md_out=%h busy=%b hi=%h required 0 0 0", md_out, busy, hi);
    end
    md_op = 4'd0;
  endtask

  task automatic test_flush_mt;
    issue(4'd8, 32'h5555, 32'd0, 1'b0);
    issue(4'd7, 32'h3333, 32'd0, 1'b0);
    issue(4'd8, 32'hAAAA, 32'd0, 1'b1);
    checks++;
    if (lo !== 32'h5555) begin
      failures++;
      $display("FAIL flush_mtlo: lo=%h required 00005555", lo);
    end
    issue(4'd1, 32'd2, 32'd2, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_mult_busy: busy=%b required 0", busy);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h3333 || lo !== 32'h5555) begin
      failures++;
      $display("FAIL flush_mult: busy=%b hi=%h lo=%h required 0 00003333 00005555", busy, hi, lo);
    end
    issue(4'd8, 32'hAAAA, 32'd0, 1'b0);
    md_op = 4'd6;
    #1;
    checks++;
    if (lo !== 32'h0000AAAA || md_out !== 32'h0000AAAA) begin
      failures++;
      $display("FAIL mtlo: lo=%h md_out=%h required 0000aaaa", lo, md_out);
    end
    md_op = 4'd5;
    #1;
    checks++;
    if (md_out !== 32'h3333) begin
      failures++;
      $display("FAIL mfhi: md_out=%h required 00003333", md_out);
    end
    md_op = 4'd0;
    #1;
    checks++;
    if (md_out !== 32'h0) begin
      failures++;
      $display("FAIL md_out_none: md_out=%h required 0", md_out);
    end
  endtask

  task automatic test_madd;
    int n;
    issue(4'd7, 32'h0, 32'd0, 1'b0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MD_MADD_EN
    issue(4'd10, 32'd1, 32'd1, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'd1 || lo !== 32'd0) begin
      failures++;
      $display("FAIL maddu: cyc=%0d hi=%h lo=%h required 5 00000001 00000000", n, hi, lo);
    end
    issue(4'd11, 32'd1, 32'd1, 1'b0);
    count_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL msub: cyc=%0d hi=%h lo=%h required 5 00000000 ffffffff", n, hi, lo);
    end
`else
    issue(4'd9, 32'd1, 32'd1, 1'b0);
    count_busy(n);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL madd_disabled: cyc=%0d hi=%h lo=%h required 0 00000000 ffffffff", n, hi, lo);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; md_op = 4'd0; start = 1'b0; flush = 1'b0; rs = '0; rt = '0;
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_async_reset();
    test_flush_mt();
    test_madd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
